reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 24 ++
 rtl/reg_scoreboard.sv | 65 ++++++
 rtl/reg_file_sb.sv | 83 ++++++++
 tb/tb_reg_file_sb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg
// Shared defaults and derived widths for the scoreboarded register file.
//   XLEN_DEF  - default register data width
//   NREGS_DEF - default register count (power of two, >= 2)
//   NRD_DEF   - default number of read ports
//   ZERO_REG  - index of the hardwired-zero register
//   addr_width(n) - register index width for an n-entry file
//   cnt_width(n)  - width needed to count 0..n busy registers
package reg_file_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int ZERO_REG  = 0;

  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

  function automatic int cnt_width(input int nregs);
    return $clog2(nregs + 1);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Busy-bit scoreboard for the register file. A reservation sets a busy bit,
// a writeback clears it; a set and clear to the same register in one cycle
// leaves it busy. busy_cnt is tracked incrementally and always equals the
// popcount of busy_vec. Register 0 is never marked busy.
// Ports:
//   clk, reset           - clock, async active-high reset
//   set_en, set_addr     - reservation request
//   clr_en, clr_addr     - writeback (clear) request
//   busy_vec             - registered busy bit per register
//   busy_cnt             - registered number of busy registers
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = addr_width(NREGS),
  localparam int CW    = cnt_width(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy_vec,
  output logic [CW-1:0]    busy_cnt
);

  localparam logic [AW-1:0] ZA  = AW'(ZERO_REG);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic             set_hit;
  logic             clr_hit;
  logic             inc;
  logic             dec;
  logic [NREGS-1:0] busy_next;

  always_comb begin
    set_hit   = set_en && (set_addr != ZA);
    clr_hit   = clr_en && (clr_addr != ZA);
    busy_next = busy_vec;
    if (clr_hit) busy_next[clr_addr] = 1'b0;
    // set is applied last so it wins a same-register collision
    if (set_hit) busy_next[set_addr] = 1'b1;
    // count only real 0->1 / 1->0 transitions so re-reserving a busy
    // register or writing an idle one leaves the count alone
    inc = set_hit && !busy_vec[set_addr];
    dec = clr_hit && busy_vec[clr_addr] && !(set_hit && (set_addr == clr_addr));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      busy_vec <= busy_next;
      if (inc && !dec) begin
        busy_cnt <= busy_cnt + ONE;
      end else if (dec && !inc) begin
        busy_cnt <= busy_cnt - ONE;
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
// Register file with NRD combinational read ports, one writeback port and a
// busy scoreboard. Register 0 reads zero, ignores writes, is never busy.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read port
// whose address matches the in-flight writeback returns rwd in the same cycle
// and reports not-busy unless the same register is being re-reserved.
// Ports:
//   clk, reset          - clock, async active-high reset
//   rs_addr / rd_data   - packed read addresses / read data, port i at slice i
//   rd_busy             - busy flag of each read port's register
//   write, rw, rwd      - writeback enable, index, data
//   rsv_valid, rsv_addr - destination reservation at issue
//   busy_vec, busy_cnt  - scoreboard state
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  localparam int AW    = addr_width(NREGS),
  localparam int CW    = cnt_width(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                write,
  input  logic [AW-1:0]       rw,
  input  logic [XLEN-1:0]     rwd,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREGS-1:0]    busy_vec,
  output logic [CW-1:0]       busy_cnt
);

  localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

  logic [XLEN-1:0] regs [NREGS];

  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (rsv_valid),
    .set_addr (rsv_addr),
    .clr_en   (write),
    .clr_addr (rw),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  // entry 0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write && (rw != ZA)) begin
      regs[rw] <= rwd;
    end
  end

  // outputs are forced low during reset so the bypass path cannot leak rwd
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!reset && (rs_addr[i*AW +: AW] != ZA)) begin
        rd_data[i*XLEN +: XLEN] = regs[rs_addr[i*AW +: AW]];
        rd_busy[i]              = busy_vec[rs_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (write && (rw == rs_addr[i*AW +: AW])) begin
          rd_data[i*XLEN +: XLEN] = rwd;
          rd_busy[i]              = rsv_valid && (rsv_addr == rw);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // default build: XLEN=32, NREGS=32, NRD=2
  logic [9:0]  rs_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        write;
  logic [4:0]  rw;
  logic [31:0] rwd;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [31:0] busy_vec;
  logic [5:0]  busy_cnt;

  // wide build: XLEN=64, NREGS=16, NRD=4
  logic [15:0]  b_rs_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_write;
  logic [3:0]   b_rw;
  logic [63:0]  b_rwd;
  logic         b_rsv_valid;
  logic [3:0]   b_rsv_addr;
  logic [15:0]  b_busy_vec;
  logic [4:0]   b_busy_cnt;

  reg_file_sb dut (
    .clk       (clk),
    .reset     (reset),
    .rs_addr   (rs_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .write     (write),
    .rw        (rw),
    .rwd       (rwd),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .busy_vec  (busy_vec),
    .busy_cnt  (busy_cnt)
  );

  reg_file_sb #(.XLEN(64), .NREGS(16), .NRD(4)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .rs_addr   (b_rs_addr),
    .rd_data   (b_rd_data),
    .rd_busy   (b_rd_busy),
    .write     (b_write),
    .rw        (b_rw),
    .rwd       (b_rwd),
    .rsv_valid (b_rsv_valid),
    .rsv_addr  (b_rsv_addr),
    .busy_vec  (b_busy_vec),
    .busy_cnt  (b_busy_cnt)
  );

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_reg  [32];
  logic        m_busy [32];
  logic [63:0] mb_reg [16];

  task automatic expect_v(input string tag, input logic [63:0] e);
    exp_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic compare(input logic [63:0] obs);
    exp_t it;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h expected none", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [5:0] model_cnt();
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) c = c + 6'd1;
    return c;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic wr,
                                         input logic [4:0] w_a, input logic [31:0] w_d);
    if (a == 5'd0) return 32'd0;
    if (BYP && wr && (w_a == a)) return w_d;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input logic wr, input logic [4:0] w_a,
                                    input logic rv, input logic [4:0] r_a);
    if (a == 5'd0) return 1'b0;
    if (BYP && wr && (w_a == a)) return rv && (r_a == w_a);
    return m_busy[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // one clock of stimulus on the default DUT: checks same-cycle reads,
  // then scoreboard state and stored data after the edge
  task automatic do_cycle(input logic wr, input logic [4:0] w_a, input logic [31:0] w_d,
                          input logic rv, input logic [4:0] r_a,
                          input logic [4:0] a0, input logic [4:0] a1);
    write     = wr;
    rw        = w_a;
    rwd       = w_d;
    rsv_valid = rv;
    rsv_addr  = r_a;
    rs_addr   = {a1, a0};
    #1;
    expect_v("pre_rd0", {32'd0, exp_rd(a0, wr, w_a, w_d)});
    expect_v("pre_rd1", {32'd0, exp_rd(a1, wr, w_a, w_d)});
    expect_v("pre_busy", {62'd0, exp_busy(a1, wr, w_a, rv, r_a), exp_busy(a0, wr, w_a, rv, r_a)});
    compare(rd_data[31:0]);
    compare(rd_data[63:32]);
    compare(rd_busy);
    @(posedge clk);
    if (wr && (w_a != 5'd0)) begin
      m_reg[w_a]  = w_d;
      m_busy[w_a] = 1'b0;
    end
    if (rv && (r_a != 5'd0)) m_busy[r_a] = 1'b1;
    expect_v("busy_vec", {32'd0, model_vec()});
    expect_v("busy_cnt", {58'd0, model_cnt()});
    #1;
    compare(busy_vec);
    compare(busy_cnt);
    write     = 1'b0;
    rsv_valid = 1'b0;
    #1;
    expect_v("post_rd0", {32'd0, m_reg[a0]});
    expect_v("post_rd1", {32'd0, m_reg[a1]});
    compare(rd_data[31:0]);
    compare(rd_data[63:32]);
  endtask

  initial begin
    logic [3:0] ad [4];

    model_clear();
    for (int i = 0; i < 16; i++) mb_reg[i] = '0;

    // reset held with traffic present: nothing may leak or stick
    reset       = 1'b1;
    write       = 1'b1;
    rw          = 5'd5;
    rwd         = 32'hFFFF_FFFF;
    rsv_valid   = 1'b1;
    rsv_addr    = 5'd5;
    rs_addr     = {5'd5, 5'd5};
    b_rs_addr   = '0;
    b_write     = 1'b0;
    b_rw        = '0;
    b_rwd       = '0;
    b_rsv_valid = 1'b0;
    b_rsv_addr  = '0;
    #1;
    expect_v("rst_rd_data", 64'd0);  compare(rd_data);
    expect_v("rst_rd_busy", 64'd0);  compare(rd_busy);
    expect_v("rst_busy_vec", 64'd0); compare(busy_vec);
    expect_v("rst_busy_cnt", 64'd0); compare(busy_cnt);
    repeat (2) @(posedge clk);
    #1;
    expect_v("rst_edge_busy_vec", 64'd0); compare(busy_vec);
    expect_v("rst_edge_rd_data", 64'd0);  compare(rd_data);
    write     = 1'b0;
    rsv_valid = 1'b0;
    reset     = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rs_addr = {5'(a), 5'(a)};
      #1;
      expect_v("init_rd", 64'd0);   compare(rd_data);
      expect_v("init_busy", 64'd0); compare(rd_busy);
    end
    @(posedge clk);
    #2;

    do_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd5);
    do_cycle(1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 5'd5, 5'd5);
    do_cycle(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd0, 5'd5);
    do_cycle(1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd3, 5'd3);
    do_cycle(1'b0, 5'd0, 32'd0,         1'b1, 5'd7, 5'd7, 5'd0);
    do_cycle(1'b1, 5'd7, 32'h0000_0055, 1'b0, 5'd0, 5'd7, 5'd7);
    do_cycle(1'b1, 5'd7, 32'h0000_0066, 1'b1, 5'd7, 5'd7, 5'd7);
    do_cycle(1'b0, 5'd0, 32'd0,         1'b1, 5'd7, 5'd7, 5'd0);
    do_cycle(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd9, 5'd7);
    do_cycle(1'b1, 5'd7, 32'h0000_0077, 1'b1, 5'd9, 5'd7, 5'd9);
    do_cycle(1'b1, 5'd9, 32'h0000_00AA, 1'b0, 5'd0, 5'd9, 5'd0);

    for (int r = 1; r < 32; r++) begin
      do_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 5'(r), 5'(r - 1));
    end
    do_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd31);

    // reset asserted mid-cycle with a write and a reservation in flight
    write     = 1'b1;
    rw        = 5'd5;
    rwd       = 32'hCAFE_F00D;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd2;
    rs_addr   = {5'd3, 5'd5};
    #2;
    reset = 1'b1;
    #1;
    expect_v("midrst_busy_cnt", 64'd0); compare(busy_cnt);
    expect_v("midrst_busy_vec", 64'd0); compare(busy_vec);
    expect_v("midrst_rd_data", 64'd0);  compare(rd_data);
    expect_v("midrst_rd_busy", 64'd0);  compare(rd_busy);
    @(posedge clk);
    #1;
    expect_v("midrst_edge_cnt", 64'd0);  compare(busy_cnt);
    expect_v("midrst_edge_data", 64'd0); compare(rd_data);
    write     = 1'b0;
    rsv_valid = 1'b0;
    reset     = 1'b0;
    model_clear();
    #1;
    do_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd5);

    for (int n = 0; n < 24; n++) begin
      do_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // wide build: fill every writable register, then random 4-port reads
    for (int r = 1; r < 16; r++) begin
      b_write = 1'b1;
      b_rw    = 4'(r);
      b_rwd   = {$urandom(), $urandom()};
      mb_reg[r] = b_rwd;
      @(posedge clk);
      #2;
    end
    b_write = 1'b0;
    for (int n = 0; n < 20; n++) begin
      for (int p = 0; p < 4; p++) begin
        ad[p] = 4'($urandom_range(0, 15));
        b_rs_addr[p*4 +: 4] = ad[p];
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        expect_v("wide_rd", mb_reg[ad[p]]);
        compare(b_rd_data[p*64 +: 64]);
      end
      expect_v("wide_busy", 64'd0);
      compare(b_rd_busy);
      @(posedge clk);
      #2;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
